// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Constants shared between the CORDIC angle front end and the quadrant
// restorer: default sample width, 2-bit quadrant codes and the saturation
// bounds used by the saturating negate at the default width.
// -----------------------------------------------------------------------------
package cordic_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    // Quadrant of the original angle, as produced by the front-end reduction.
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // Two's complement bounds at the default width.
    localparam logic [DATA_WIDTH_DEF-1:0] MAX = {1'b0, {(DATA_WIDTH_DEF-1){1'b1}}};
    localparam logic [DATA_WIDTH_DEF-1:0] MIN = {1'b1, {(DATA_WIDTH_DEF-1){1'b0}}};

endpackage

// File: rtl/tag_fifo.sv
// -----------------------------------------------------------------------------
// tag_fifo
// Small FIFO of 2-bit quadrant tags. A push into a full FIFO is only accepted
// when a pop happens in the same cycle; a pop from an empty FIFO is ignored
// (a same-cycle push is still stored, there is no bypass path).
// Ports:
//   clk, rst (async, active-low), clk_en (low freezes all state)
//   push/din   : write request and tag
//   pop        : read request; dout shows the head tag combinationally
//   full/empty : status derived from count
//   count      : number of stored tags, 0..TAG_DEPTH
// -----------------------------------------------------------------------------
module tag_fifo #(
    parameter  int TAG_DEPTH = 4,
    localparam int PW        = $clog2(TAG_DEPTH),
    localparam int CW        = $clog2(TAG_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    input  logic          push,
    input  logic [1:0]    din,
    input  logic          pop,
    output logic [1:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [1:0]    mem_q [TAG_DEPTH];
    logic [1:0]    mem_d [TAG_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full  = (count_q == CW'(TAG_DEPTH));
    assign empty = (count_q == CW'(0));
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // A pop frees the slot a simultaneous push needs when the FIFO is full.
    assign pop_ok_s  = clk_en & pop & ~empty;
    assign push_ok_s = clk_en & push & (~full | pop_ok_s);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                mem_q[i] <= 2'b00;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/quadrant_restorer.sv
// -----------------------------------------------------------------------------
// quadrant_restorer
// Re-applies the quadrant removed by the CORDIC angle front end. Quadrant tags
// are queued in order; each core result consumes the oldest tag and is rotated
// by 0/90/180/270 degrees with saturating negation, then registered.
// Ports:
//   clk, rst (async, active-low), clk_en (low freezes all state)
//   tag_valid/tag_in         : quadrant tag from the front end
//   core_valid/cos_in/sin_in : core result for the reduced angle
//   cos_out/sin_out/done     : registered corrected result, done = 1-cycle pulse
//   tag_full                 : tag FIFO is full
//   ovf / unf                : sticky tag-dropped / result-dropped flags
// -----------------------------------------------------------------------------
module quadrant_restorer
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  tag_valid,
    input  logic [1:0]            tag_in,
    input  logic                  core_valid,
    input  logic [DATA_WIDTH-1:0] cos_in,
    input  logic [DATA_WIDTH-1:0] sin_in,
    output logic [DATA_WIDTH-1:0] cos_out,
    output logic [DATA_WIDTH-1:0] sin_out,
    output logic                  done,
    output logic                  tag_full,
    output logic                  ovf,
    output logic                  unf
);

    localparam int CW = $clog2(TAG_DEPTH + 1);

    // Width-generic bounds; they equal cordic_pkg MAX/MIN at the default width.
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // -MIN does not exist in two's complement; clamp it to MAX.
    function automatic logic [DATA_WIDTH-1:0] sat_neg(input logic [DATA_WIDTH-1:0] x);
        if (x == SAT_MIN) begin
            return SAT_MAX;
        end else begin
            return ~x + DATA_WIDTH'(1);
        end
    endfunction

    logic [1:0]            fifo_tag_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [CW-1:0]         fifo_count_s;
    logic                  pop_ok_s;
    logic                  ovf_evt_s;
    logic                  unf_evt_s;
    logic [DATA_WIDTH-1:0] cos_fix_s, sin_fix_s;

    logic [DATA_WIDTH-1:0] cos_q, cos_d;
    logic [DATA_WIDTH-1:0] sin_q, sin_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    tag_fifo #(
        .TAG_DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .push   (tag_valid),
        .din    (tag_in),
        .pop    (core_valid),
        .dout   (fifo_tag_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s),
        .count  (fifo_count_s)
    );

    assign pop_ok_s  = clk_en & core_valid & ~fifo_empty_s;
    // A full FIFO always has a head to pop, so core_valid alone makes room.
    assign ovf_evt_s = clk_en & tag_valid & fifo_full_s & ~core_valid;
    assign unf_evt_s = clk_en & core_valid & fifo_empty_s;

    // Rotate the core result back into the quadrant of the head tag.
    always_comb begin
        cos_fix_s = cos_in;
        sin_fix_s = sin_in;
        case (fifo_tag_s)
            Q0: begin
                cos_fix_s = cos_in;
                sin_fix_s = sin_in;
            end
            Q1: begin
                cos_fix_s = sat_neg(sin_in);
                sin_fix_s = cos_in;
            end
            Q2: begin
                cos_fix_s = sat_neg(cos_in);
                sin_fix_s = sat_neg(sin_in);
            end
            Q3: begin
                cos_fix_s = sin_in;
                sin_fix_s = sat_neg(cos_in);
            end
            default: begin
                cos_fix_s = cos_in;
                sin_fix_s = sin_in;
            end
        endcase
    end

    // Output, done pulse and sticky error flag next-state.
    always_comb begin
        cos_d  = cos_q;
        sin_d  = sin_q;
        done_d = done_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        if (clk_en) begin
            done_d = pop_ok_s;
            if (pop_ok_s) begin
                cos_d = cos_fix_s;
                sin_d = sin_fix_s;
            end else begin
                cos_d = cos_q;
                sin_d = sin_q;
            end
            ovf_d = ovf_q | ovf_evt_s;
            unf_d = unf_q | unf_evt_s;
        end else begin
            done_d = done_q;
        end
    end

    // Output and flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cos_q  <= '0;
            sin_q  <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            cos_q  <= cos_d;
            sin_q  <= sin_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign cos_out  = cos_q;
    assign sin_out  = sin_q;
    assign done     = done_q;
    assign ovf      = ovf_q;
    assign unf      = unf_q;
    assign tag_full = fifo_full_s;

endmodule

// File: tb/tb_quadrant_restorer.sv
// -----------------------------------------------------------------------------
// tb_quadrant_restorer
// Scoreboard bench: a reference tag queue decides which tag each accepted core
// result uses; the expected corrected pair is queued at stimulus time and
// popped when the DUT raises done.
// -----------------------------------------------------------------------------
module tb_quadrant_restorer;

    localparam int DW = 32;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          clk_en     = 1'b0;
    logic          tag_valid  = 1'b0;
    logic [1:0]    tag_in     = 2'd0;
    logic          core_valid = 1'b0;
    logic [DW-1:0] cos_in     = 32'h0;
    logic [DW-1:0] sin_in     = 32'h0;
    logic [DW-1:0] cos_out;
    logic [DW-1:0] sin_out;
    logic          done;
    logic          tag_full;
    logic          ovf;
    logic          unf;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [1:0]  m_tags [$];
    logic [63:0] exp_q  [$];
    logic        m_done = 1'b0;
    logic        m_ovf  = 1'b0;
    logic        m_unf  = 1'b0;
    logic [63:0] got;
    logic [63:0] exp_v;

    quadrant_restorer #(
        .DATA_WIDTH (DW),
        .TAG_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .tag_valid  (tag_valid),
        .tag_in     (tag_in),
        .core_valid (core_valid),
        .cos_in     (cos_in),
        .sin_in     (sin_in),
        .cos_out    (cos_out),
        .sin_out    (sin_out),
        .done       (done),
        .tag_full   (tag_full),
        .ovf        (ovf),
        .unf        (unf)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] neg(input logic [DW-1:0] x);
        if (x == 32'h8000_0000) return 32'h7FFF_FFFF;
        return 32'h0000_0000 - x;
    endfunction

    function automatic logic [63:0] quad(input logic [1:0] t, input logic [DW-1:0] c,
                                         input logic [DW-1:0] s);
        case (t)
            2'd0:    return {c, s};
            2'd1:    return {neg(s), c};
            2'd2:    return {neg(c), neg(s)};
            default: return {s, neg(c)};
        endcase
    endfunction

    // Drive one clock of stimulus and advance the reference model.
    task automatic drive_cycle(input logic en, input logic tv, input logic [1:0] tg,
                               input logic cv, input logic [DW-1:0] c, input logic [DW-1:0] s);
        bit full_b, empty_b, pop_ok;
        logic [1:0] t;
        clk_en = en; tag_valid = tv; tag_in = tg; core_valid = cv; cos_in = c; sin_in = s;
        if (en) begin
            full_b  = (m_tags.size() == 4);
            empty_b = (m_tags.size() == 0);
            pop_ok  = cv && !empty_b;
            m_done  = pop_ok;
            if (pop_ok) begin
                t = m_tags.pop_front();
                exp_q.push_back(quad(t, c, s));
            end
            if (tv && (!full_b || pop_ok)) m_tags.push_back(tg);
            if (tv && full_b && !cv) m_ovf = 1'b1;
            if (cv && empty_b) m_unf = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        clk_en = 1'b0; tag_valid = 1'b0; core_valid = 1'b0;
        rst = 1'b0;
        m_tags.delete(); exp_q.delete();
        m_done = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (cos_out !== 32'h0) begin n_fail++; $display("FAIL reset_cos: got %h want 0", cos_out); end
        n_cmp++; if (sin_out !== 32'h0) begin n_fail++; $display("FAIL reset_sin: got %h want 0", sin_out); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (tag_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", tag_full); end
        n_cmp++; if ({ovf, unf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {ovf, unf}); end
        apply_reset();
    endtask

    task automatic test_map();
        logic [63:0] lit [4];
        lit = '{64'h40000000_10000000, 64'hF0000000_40000000,
                64'hC0000000_F0000000, 64'h10000000_C0000000};
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b1, 2'(i), 1'b0, 32'h0, 32'h0);
        n_cmp++; if (tag_full !== 1'b1) begin n_fail++; $display("FAIL map_full: got %b want 1", tag_full); end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 1'b0, 2'd0, 1'b1, 32'h4000_0000, 32'h1000_0000);
            n_cmp++; if (done !== m_done) begin n_fail++; $display("FAIL map_done[%0d]: got %b want %b", i, done, m_done); end
            got = {cos_out, sin_out};
            if (m_done) begin
                exp_v = exp_q.pop_front();
                n_cmp++; if (got !== exp_v) begin n_fail++; $display("FAIL map_sb[%0d]: got %h want %h", i, got, exp_v); end
            end
            n_cmp++; if (got !== lit[i]) begin n_fail++; $display("FAIL map_lit[%0d]: got %h want %h", i, got, lit[i]); end
        end
        drive_cycle(1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL map_done_drop: got %b want 0", done); end
        got = {cos_out, sin_out};
        n_cmp++; if (got !== lit[3]) begin n_fail++; $display("FAIL map_hold: got %h want %h", got, lit[3]); end
    endtask

    task automatic test_saturate();
        drive_cycle(1'b1, 1'b1, 2'd2, 1'b0, 32'h0, 32'h0);
        drive_cycle(1'b1, 1'b0, 2'd0, 1'b1, 32'h8000_0000, 32'h0000_0001);
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL sat_done: got %b want 1", done); end
        got = {cos_out, sin_out};
        n_cmp++; if (got !== 64'h7FFFFFFF_FFFFFFFF) begin n_fail++; $display("FAIL sat_lit: got %h want 7fffffffffffffff", got); end
        exp_v = exp_q.pop_front();
        n_cmp++; if (got !== exp_v) begin n_fail++; $display("FAIL sat_sb: got %h want %h", got, exp_v); end
    endtask

    task automatic test_overflow();
        logic [1:0] tg [5];
        tg = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 1'b1, tg[i], 1'b0, 32'h0, 32'h0);
            if (i == 3) begin
                n_cmp++; if ({tag_full, ovf} !== 2'b10) begin n_fail++; $display("FAIL ovf_full4: got %b want 10", {tag_full, ovf}); end
            end
        end
        n_cmp++; if ({tag_full, ovf} !== {1'b1, m_ovf}) begin n_fail++; $display("FAIL ovf_set: got %b want %b", {tag_full, ovf}, {1'b1, m_ovf}); end
        // push and pop together while full
        drive_cycle(1'b1, 1'b1, 2'd3, 1'b1, 32'h0100_0000, 32'h0200_0000);
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL ovf_pp_done: got %b want 1", done); end
        exp_v = exp_q.pop_front(); got = {cos_out, sin_out};
        n_cmp++; if (got !== exp_v) begin n_fail++; $display("FAIL ovf_pp_sb: got %h want %h", got, exp_v); end
        n_cmp++; if (dut.u_tag_fifo.count !== 3'd4) begin n_fail++; $display("FAIL ovf_pp_count: got %0d want 4", dut.u_tag_fifo.count); end
        n_cmp++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_pp_ovf: got %b want 1", ovf); end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 1'b0, 2'd0, 1'b1, 32'h2000_0000 + 32'(i), 32'h8000_0000);
            n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL ovf_pop_done[%0d]: got %b want 1", i, done); end
            exp_v = exp_q.pop_front(); got = {cos_out, sin_out};
            n_cmp++; if (got !== exp_v) begin n_fail++; $display("FAIL ovf_pop_sb[%0d]: got %h want %h", i, got, exp_v); end
        end
        n_cmp++; if ({tag_full, ovf, unf} !== 3'b010) begin n_fail++; $display("FAIL ovf_end: got %b want 010", {tag_full, ovf, unf}); end
    endtask

    task automatic test_underflow();
        apply_reset();
        drive_cycle(1'b1, 1'b1, 2'd1, 1'b1, 32'h4000_0000, 32'h1000_0000);
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL unf_done: got %b want 0", done); end
        n_cmp++; if (unf !== m_unf) begin n_fail++; $display("FAIL unf_flag: got %b want %b", unf, m_unf); end
        n_cmp++; if (dut.u_tag_fifo.count !== 3'd1) begin n_fail++; $display("FAIL unf_count: got %0d want 1", dut.u_tag_fifo.count); end
        drive_cycle(1'b1, 1'b0, 2'd0, 1'b1, 32'h4000_0000, 32'h1000_0000);
        n_cmp++; if (done !== 1'b1) begin n_fail++; $display("FAIL unf_next_done: got %b want 1", done); end
        exp_v = exp_q.pop_front(); got = {cos_out, sin_out};
        n_cmp++; if (got !== exp_v || got !== 64'hF0000000_40000000) begin n_fail++; $display("FAIL unf_next: got %h want %h", got, exp_v); end
    endtask

    task automatic test_clk_en();
        logic [63:0] held;
        drive_cycle(1'b1, 1'b1, 2'd3, 1'b0, 32'h0, 32'h0);
        drive_cycle(1'b1, 1'b1, 2'd2, 1'b1, 32'h0300_0000, 32'h0500_0000);
        exp_v = exp_q.pop_front(); held = {cos_out, sin_out};
        n_cmp++; if (held !== exp_v || done !== 1'b1) begin n_fail++; $display("FAIL en_pre: got %h/%b want %h/1", held, done, exp_v); end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b1, 2'd0, 1'b1, 32'h1111_1111, 32'h2222_2222);
            got = {cos_out, sin_out};
            n_cmp++; if (got !== held || done !== 1'b1) begin n_fail++; $display("FAIL en_hold[%0d]: got %h/%b want %h/1", i, got, done, held); end
        end
        n_cmp++; if (dut.u_tag_fifo.count !== 3'd1 || unf !== 1'b1 || ovf !== 1'b0) begin n_fail++; $display("FAIL en_state: got count %0d ovf %b unf %b want 1 0 1", dut.u_tag_fifo.count, ovf, unf); end
        drive_cycle(1'b1, 1'b0, 2'd0, 1'b1, 32'h0700_0000, 32'h0900_0000);
        exp_v = exp_q.pop_front(); got = {cos_out, sin_out};
        n_cmp++; if (got !== exp_v || done !== 1'b1) begin n_fail++; $display("FAIL en_resume: got %h/%b want %h/1", got, done, exp_v); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 2'(i + 1), 1'b0, 32'h0, 32'h0);
        #3 rst = 1'b0;
        #1;
        n_cmp++; if ({cos_out, sin_out} !== 64'h0) begin n_fail++; $display("FAIL rmid_out: got %h want 0", {cos_out, sin_out}); end
        n_cmp++; if ({done, tag_full, ovf, unf} !== 4'b0000) begin n_fail++; $display("FAIL rmid_flags: got %b want 0000", {done, tag_full, ovf, unf}); end
        n_cmp++; if (dut.u_tag_fifo.count !== 3'd0) begin n_fail++; $display("FAIL rmid_count: got %0d want 0", dut.u_tag_fifo.count); end
        m_tags.delete(); exp_q.delete(); m_done = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        clk_en = 1'b0; tag_valid = 1'b0; core_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        drive_cycle(1'b1, 1'b0, 2'd0, 1'b1, 32'h4000_0000, 32'h1000_0000);
        n_cmp++; if ({done, unf} !== {m_done, m_unf}) begin n_fail++; $display("FAIL rmid_after: got %b want %b", {done, unf}, {m_done, m_unf}); end
    endtask

    initial begin
        test_reset();
        test_map();
        test_saturate();
        test_overflow();
        test_underflow();
        test_clk_en();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/quadrant_restorer.md
QUADRANT_RESTORER -- requirements
Module: quadrant_restorer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of cos/sin samples in two's complement.
REQ-002 Parameter TAG_DEPTH, default 4, quadrant-tag FIFO depth (power of two, >=2).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 clk_en  input  1  global enable; low freezes all state.
REQ-006 tag_valid  input  1  quadrant tag from the angle front end is valid this cycle.
REQ-007 tag_in  input  2  quadrant code of the reduced angle.
REQ-008 core_valid  input  1  CORDIC core result valid this cycle.
REQ-009 cos_in  input  DATA_WIDTH  core cosine result for the reduced angle.
REQ-010 sin_in  input  DATA_WIDTH  core sine result for the reduced angle.
REQ-011 cos_out  output  DATA_WIDTH  corrected cosine, registered.
REQ-012 sin_out  output  DATA_WIDTH  corrected sine, registered.
REQ-013 done  output  1  cos_out/sin_out updated this cycle, registered.
REQ-014 tag_full  output  1  tag FIFO holds TAG_DEPTH entries.
REQ-015 ovf  output  1  sticky: tag dropped because FIFO full.
REQ-016 unf  output  1  sticky: core result dropped because FIFO empty.

Function
REQ-017 Tags shall be pushed in order on clk_en & tag_valid and popped on clk_en & core_valid; the n-th core result shall use the n-th tag (FIFO order).
REQ-018 Quadrant mapping (c=cos_in, s=sin_in): 0 -> (c, s); 1 -> (-s, c); 2 -> (-c, -s); 3 -> (s, -c).
REQ-019 Negation shall be two's complement and saturate: -(most-negative) yields most-positive.
REQ-020 Latency: cos_out/sin_out/done shall be valid on the clock edge after the accepted core_valid cycle (1 cycle).
REQ-021 done shall be a single-cycle pulse per accepted result; done shall deassert on the next enabled edge with no accepted result.
REQ-022 With clk_en low, FIFO contents, pointers, count, outputs, done, ovf and unf shall all hold.
REQ-023 Push while full and no pop: tag shall be discarded, FIFO unchanged, ovf set.
REQ-024 Push while full with simultaneous pop: both shall occur; count unchanged; ovf unchanged.
REQ-025 core_valid while empty: result shall be discarded, no done, unf set; a simultaneous push shall still be stored (no bypass).
REQ-026 Pointers shall wrap modulo TAG_DEPTH; count shall range 0..TAG_DEPTH; tag_full = (count == TAG_DEPTH), combinational from count.
REQ-027 ovf and unf shall clear only on reset.
REQ-028 Output registers shall hold their last value between done pulses.

Reset
REQ-029 rst low shall immediately clear cos_out, sin_out, done, ovf, unf, FIFO count and both pointers to 0, independent of clk and clk_en.
REQ-030 Reset mid-operation shall discard all queued tags and any in-flight result; first done after release requires a new tag and core result.
REQ-031 Release of rst shall be taken synchronously to clk; the first enabled edge after release is a normal operating cycle.

Structure
REQ-032 Shared package cordic_pkg shall hold DATA_WIDTH default, the 2-bit quadrant code constants (Q0..Q3) and saturated-negate constants MAX/MIN, shared with the angle front end.
REQ-033 The tag FIFO shall be a sub-module tag_fifo (parameter TAG_DEPTH, 2-bit data, push/pop/full/empty/count).
REQ-034 Quadrant correction and saturation shall be in quadrant_restorer itself, feeding the output registers.

Verification
REQ-035 Tags 0,1,2,3 pushed, then four core results c=0x4000_0000, s=0x1000_0000 -> done pulses in order, outputs (4000_0000,1000_0000), (F000_0000,4000_0000), (C000_0000,F000_0000), (1000_0000,C000_0000).
REQ-036 Tag 2 with c=0x8000_0000, s=0x0000_0001 -> cos_out=0x7FFF_FFFF, sin_out=0xFFFF_FFFF.
REQ-037 Five pushes, no pops (depth 4) -> tag_full=1 after 4th, ovf=1 after 5th, next four results use tags 1..4.
REQ-038 core_valid with empty FIFO and simultaneous tag_valid tag=1 -> no done, unf=1, count=1; next result uses tag 1.
REQ-039 clk_en held low 3 cycles with tag_valid and core_valid high -> no state change, done/outputs held.
REQ-040 rst pulsed low with 3 tags queued -> all outputs 0, tag_full=0, ovf=unf=0 immediately; subsequent core_valid sets unf.
